// File: rtl/layer_sequencer.sv
// layer_sequencer: launches LAYER_NUM layer engines in order for each of IMAGE_NUM images.
// Optional per-layer watchdog is compiled in by defining LAYER_WATCHDOG_EN.
module layer_sequencer #(
  parameter int IMAGE_NUM   = 5,
  parameter int LAYER_NUM   = 3,
  parameter int WDOG_CYCLES = 4096,
  localparam int IMAGE_W = (IMAGE_NUM > 1) ? $clog2(IMAGE_NUM) : 1,
  localparam int LAYER_W = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LAYER_NUM-1:0] layer_fin,
  output logic [LAYER_NUM-1:0] layer_en,
  output logic [LAYER_NUM-1:0] layer_start,
  output logic [IMAGE_W-1:0]   image_idx,
  output logic [LAYER_W-1:0]   layer_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 wdog_err
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t               state_q, state_d;
  logic [LAYER_NUM-1:0] layer_en_q, layer_en_d;
  logic [LAYER_NUM-1:0] layer_start_q, layer_start_d;
  logic [IMAGE_W-1:0]   image_idx_q, image_idx_d;
  logic [LAYER_W-1:0]   layer_idx_q, layer_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fin_ok;
  logic                 timeout;

  // Only the enabled layer's fin counts, and never in its own launch cycle.
  assign fin_ok = (state_q == RUN) && (|(layer_fin & layer_en_q)) && !(|layer_start_q);

  always_comb begin
    state_d       = state_q;
    layer_en_d    = layer_en_q;
    layer_start_d = '0;
    image_idx_d   = image_idx_q;
    layer_idx_d   = layer_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          image_idx_d   = '0;
          layer_idx_d   = '0;
          layer_en_d    = LAYER_NUM'(1);
          layer_start_d = LAYER_NUM'(1);
          busy_d        = 1'b1;
        end
      end
      RUN: begin
        if (fin_ok) begin
          state_d    = GAP;
          layer_en_d = '0;
        end else if (timeout) begin
          state_d     = IDLE;
          layer_en_d  = '0;
          busy_d      = 1'b0;
          image_idx_d = '0;
          layer_idx_d = '0;
        end
      end
      GAP: begin
        if (layer_idx_q < LAYER_W'(LAYER_NUM - 1)) begin
          state_d       = RUN;
          layer_idx_d   = layer_idx_q + LAYER_W'(1);
          layer_en_d    = LAYER_NUM'(1) << layer_idx_d;
          layer_start_d = LAYER_NUM'(1) << layer_idx_d;
        end else if (image_idx_q < IMAGE_W'(IMAGE_NUM - 1)) begin
          state_d       = RUN;
          layer_idx_d   = '0;
          image_idx_d   = image_idx_q + IMAGE_W'(1);
          layer_en_d    = LAYER_NUM'(1);
          layer_start_d = LAYER_NUM'(1);
        end else begin
          state_d     = IDLE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          image_idx_d = '0;
          layer_idx_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything above, including a pending done.
    if (abort) begin
      state_d       = IDLE;
      layer_en_d    = '0;
      layer_start_d = '0;
      image_idx_d   = '0;
      layer_idx_d   = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      layer_en_q    <= '0;
      layer_start_q <= '0;
      image_idx_q   <= '0;
      layer_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_en_q    <= layer_en_d;
      layer_start_q <= layer_start_d;
      image_idx_q   <= image_idx_d;
      layer_idx_q   <= layer_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign layer_en    = layer_en_q;
  assign layer_start = layer_start_q;
  assign image_idx   = image_idx_q;
  assign layer_idx   = layer_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef LAYER_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q;

  // Timeout fires on the edge that ends the WDOG_CYCLES-th RUN cycle; fin_ok wins a tie.
  assign timeout = (state_q == RUN) && !fin_ok && (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (|layer_start_d) begin
      wdog_cnt_d = '0;
    end else if (state_q == RUN) begin
      wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (timeout) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic unused_wdog;

  assign timeout     = 1'b0;
  assign wdog_err    = 1'b0;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

endmodule
